// File: rtl/adder_rr_sequencer.sv
// Two requesters share one 4-bit ripple adder. A round-robin arbiter picks
// one of them, and its WIDTH-bit operands are then added one nibble per clock.

module fourBitAdder_FourByOne (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_cin,
    output logic [3:0] o_sum,
    output logic       o_cout
);
    logic [4:0] w_carry;

    always_comb begin
        w_carry    = '0;
        o_sum      = '0;
        w_carry[0] = i_cin;
        for (int i = 0; i < 4; i++) begin
            o_sum[i]     = i_a[i] ^ i_b[i] ^ w_carry[i];
            w_carry[i+1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
        end
        o_cout = w_carry[4];
    end
endmodule

module adder_rr_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout
);
    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int unsigned IW  = (WIDTH > 4) ? $clog2(WIDTH) : 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_n;
    logic             r_last_id, w_last_id_n;
    logic [KW-1:0]    r_k, w_k_n;
    logic             r_carry, w_carry_n;
    logic [WIDTH-1:0] r_a, w_a_n;
    logic [WIDTH-1:0] r_b, w_b_n;
    logic             r_cin, w_cin_n;
    logic             r_id, w_id_n;
    logic [WIDTH-1:0] r_sum, w_sum_n;

    logic             w_pref;
    logic             w_grant;
    logic             w_accept;
    logic [IW-1:0]    w_idx;
    logic [3:0]       w_nib_sum;
    logic             w_nib_cout;
    logic             w_nib_cin;

    // Prefer the requester that was not served last; fall back to the other one.
    always_comb begin
        w_pref  = ~r_last_id;
        w_grant = w_pref;
        if (w_pref == 1'b0) begin
            if (!req0_valid && req1_valid) w_grant = 1'b1;
        end else begin
            if (!req1_valid && req0_valid) w_grant = 1'b0;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (w_grant ? req1_valid : req0_valid);
    assign req0_ready = (r_state == S_IDLE) && !w_grant;
    assign req1_ready = (r_state == S_IDLE) && w_grant;

    assign w_idx     = IW'({r_k, 2'b00});
    assign w_nib_cin = (r_k == '0) ? r_cin : r_carry;

    fourBitAdder_FourByOne u_adder (
        .i_a    (r_a[w_idx +: 4]),
        .i_b    (r_b[w_idx +: 4]),
        .i_cin  (w_nib_cin),
        .o_sum  (w_nib_sum),
        .o_cout (w_nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_last_id <= 1'b1;
            r_k       <= '0;
            r_carry   <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_cin     <= 1'b0;
            r_id      <= 1'b0;
            r_sum     <= '0;
        end else begin
            r_state   <= w_state_n;
            r_last_id <= w_last_id_n;
            r_k       <= w_k_n;
            r_carry   <= w_carry_n;
            r_a       <= w_a_n;
            r_b       <= w_b_n;
            r_cin     <= w_cin_n;
            r_id      <= w_id_n;
            r_sum     <= w_sum_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_last_id_n = r_last_id;
        w_k_n       = r_k;
        w_carry_n   = r_carry;
        w_a_n       = r_a;
        w_b_n       = r_b;
        w_cin_n     = r_cin;
        w_id_n      = r_id;
        w_sum_n     = r_sum;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_n   = S_RUN;
                    w_a_n       = w_grant ? req1_a : req0_a;
                    w_b_n       = w_grant ? req1_b : req0_b;
                    w_cin_n     = w_grant ? req1_cin : req0_cin;
                    w_id_n      = w_grant;
                    w_last_id_n = w_grant;
                    w_k_n       = '0;
                end
            end
            S_RUN: begin
                w_sum_n[w_idx +: 4] = w_nib_sum;
                w_carry_n           = w_nib_cout;
                // The last nibble ends the sequence; k is left in place, no wrap.
                if (r_k == KW'(NIB - 1)) w_state_n = S_DONE;
                else                     w_k_n     = r_k + KW'(1);
            end
            S_DONE: begin
                if (rsp_ready) w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_carry;
endmodule
